// File: rtl/intersection_timed_if.sv
// Signal bundle between the board sensors / LED matrix driver and the intersection controller.
// The controller takes the slave view; the board side (or a testbench) takes the master view.
interface intersection_timed_if;
  logic              SN;
  logic              SS;
  logic              flash;
  logic [2:0]        phase;
  logic [15:0][15:0] RedPixels;
  logic [15:0][15:0] GrnPixels;

  modport master (output SN, SS, flash, input phase, RedPixels, GrnPixels);
  modport slave  (input SN, SS, flash, output phase, RedPixels, GrnPixels);
endinterface

// File: rtl/intersection_timed.sv
// Highway/side-street traffic-light controller with all-red clearance and night flashing,
// driving the 16x16 red/green LED matrix as a Moore decode of the current phase.
module intersection_timed #(
  parameter int GREEN_MIN  = 8,
  parameter int GREEN_SIDE = 6,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int FLASH_CYC  = 4,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  intersection_timed_if.slave  bus
);

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5,
    FL  = 3'd6
  } phase_e;

  // Lamp colour as {red, green}; yellow lights both LEDs.
  localparam logic [1:0] OFF = 2'b00;
  localparam logic [1:0] RED = 2'b10;
  localparam logic [1:0] GRN = 2'b01;
  localparam logic [1:0] YEL = 2'b11;

  localparam logic [15:0] HN_MASK = 16'h00E0;
  localparam logic [15:0] HS_MASK = 16'h0700;

  phase_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic               req_q, req_d;
  logic               blink_q, blink_d;
  logic               done;
  logic [1:0]         hw_col, sd_col;
  logic [15:0][15:0]  red_px, grn_px;

  function automatic logic [CNT_W-1:0] load_val(phase_e s);
    case (s)
      HG:       load_val = CNT_W'(GREEN_MIN - 1);
      HY, SY:   load_val = CNT_W'(YELLOW_CYC - 1);
      SG:       load_val = CNT_W'(GREEN_SIDE - 1);
      FL:       load_val = CNT_W'(FLASH_CYC - 1);
      default:  load_val = CNT_W'(ALLRED_CYC - 1);
    endcase
  endfunction

  assign done = (timer_q == '0);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    timer_d = done ? '0 : timer_q - CNT_W'(1);
    blink_d = blink_q;
    req_d   = req_q | ((bus.SN | bus.SS) & (state_q != SG));

    case (state_q)
      HG:  if (bus.flash || (done && req_q)) state_d = HY;
      HY:  if (done) state_d = AR1;
      AR1: if (done) state_d = bus.flash ? FL : SG;
      SG:  if (bus.flash || done) state_d = SY;
      SY:  if (done) state_d = AR2;
      AR2: if (done) state_d = bus.flash ? FL : HG;
      FL: begin
        if (!bus.flash) begin
          state_d = AR2;
        end else if (done) begin
          blink_d = ~blink_q;
          timer_d = load_val(FL);
        end
      end
      default: state_d = AR2;
    endcase

    // Entering a new phase reloads its duration; serving the side street consumes the request.
    if (state_d != state_q) begin
      timer_d = load_val(state_d);
      if (state_d == FL) blink_d = 1'b1;
      if (state_d == SG) req_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q <= AR2;
      timer_q <= CNT_W'(ALLRED_CYC - 1);
      req_q   <= 1'b0;
      blink_q <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      req_q   <= req_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    hw_col = RED;
    sd_col = RED;
    case (state_q)
      HG:      hw_col = GRN;
      HY:      hw_col = YEL;
      SG:      sd_col = GRN;
      SY:      sd_col = YEL;
      FL: begin
        hw_col = blink_q ? YEL : OFF;
        sd_col = blink_q ? RED : OFF;
      end
      default: ;
    endcase

    red_px     = '0;
    grn_px     = '0;
    red_px[0]  = hw_col[1] ? HN_MASK : '0;
    grn_px[0]  = hw_col[0] ? HN_MASK : '0;
    red_px[15] = hw_col[1] ? HS_MASK : '0;
    grn_px[15] = hw_col[0] ? HS_MASK : '0;
    for (int r = 7; r <= 9; r++) begin
      red_px[r][15] = sd_col[1];
      grn_px[r][15] = sd_col[0];
    end
    for (int r = 6; r <= 8; r++) begin
      red_px[r][0] = sd_col[1];
      grn_px[r][0] = sd_col[0];
    end
  end

  assign bus.phase     = state_q;
  assign bus.RedPixels = red_px;
  assign bus.GrnPixels = grn_px;

endmodule

// File: tb/tb_intersection_timed.sv
// Directed bench for intersection_timed: default-parameter instance plus a short-duration instance.
module tb_intersection_timed;

  typedef logic [15:0][15:0] px_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  intersection_timed_if bus();
  intersection_timed_if bus_f();

  intersection_timed u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  intersection_timed #(
    .GREEN_MIN  (1),
    .YELLOW_CYC (1),
    .ALLRED_CYC (1)
  ) u_fast (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_f)
  );

  // Expected lamp pattern: hw lights HN/HS in this plane, sd lights SW/SE in this plane.
  function automatic px_t mk_px(input logic hw, input logic sd);
    px_t p = '0;
    if (hw) begin
      p[0]  = 16'h00E0;
      p[15] = 16'h0700;
    end
    if (sd) begin
      p[7][15] = 1'b1; p[8][15] = 1'b1; p[9][15] = 1'b1;
      p[6][0]  = 1'b1; p[7][0]  = 1'b1; p[8][0]  = 1'b1;
    end
    return p;
  endfunction

  function automatic px_t exp_red(input logic [2:0] ph, input logic blk);
    case (ph)
      3'd0:    return mk_px(1'b0, 1'b1);
      3'd3:    return mk_px(1'b1, 1'b0);
      3'd6:    return blk ? mk_px(1'b1, 1'b1) : mk_px(1'b0, 1'b0);
      default: return mk_px(1'b1, 1'b1);
    endcase
  endfunction

  function automatic px_t exp_grn(input logic [2:0] ph, input logic blk);
    case (ph)
      3'd0, 3'd1: return mk_px(1'b1, 1'b0);
      3'd3, 3'd4: return mk_px(1'b0, 1'b1);
      3'd6:       return blk ? mk_px(1'b1, 1'b0) : mk_px(1'b0, 1'b0);
      default:    return mk_px(1'b0, 1'b0);
    endcase
  endfunction

  // Leaves the bench on the negedge where reset drops: the first AR2 cycle.
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.phase !== 3'd5) begin n_fail++; $display("FAIL reset_phase: got %0d want 5", bus.phase); end
    n_checks++;
    if (bus.RedPixels !== mk_px(1'b1, 1'b1)) begin n_fail++; $display("FAIL reset_red: got %h want %h", bus.RedPixels, mk_px(1'b1, 1'b1)); end
    n_checks++;
    if (bus.GrnPixels !== '0) begin n_fail++; $display("FAIL reset_grn: got %h want 0", bus.GrnPixels); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (bus.phase !== 3'd5) begin n_fail++; $display("FAIL reset_ar2_c%0d: got %0d want 5", c, bus.phase); end
      @(negedge clk);
    end
    for (int c = 0; c < 50; c++) begin
      n_checks++;
      if (bus.phase !== 3'd0) begin n_fail++; $display("FAIL idle_hg_c%0d: got %0d want 0", c, bus.phase); end
      @(negedge clk);
    end
    n_checks++;
    if (bus.GrnPixels[0] !== 16'h00E0) begin n_fail++; $display("FAIL idle_grn_row0: got %h want 00e0", bus.GrnPixels[0]); end
    n_checks++;
    if (bus.RedPixels[0] !== 16'h0000) begin n_fail++; $display("FAIL idle_red_row0: got %h want 0000", bus.RedPixels[0]); end
    n_checks++;
    if (bus.RedPixels !== exp_red(3'd0, 1'b1)) begin n_fail++; $display("FAIL idle_red: got %h want %h", bus.RedPixels, exp_red(3'd0, 1'b1)); end
    n_checks++;
    if (bus.GrnPixels !== exp_grn(3'd0, 1'b1)) begin n_fail++; $display("FAIL idle_grn: got %h want %h", bus.GrnPixels, exp_grn(3'd0, 1'b1)); end
  endtask

  task automatic test_side_pulse();
    logic [2:0] seq_ph [5];
    int         seq_n  [5];
    seq_ph = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    seq_n  = '{3, 2, 6, 3, 2};
    apply_reset();
    @(negedge clk);
    @(negedge clk);
    for (int c = 1; c <= 8; c++) begin
      n_checks++;
      if (bus.phase !== 3'd0) begin n_fail++; $display("FAIL pulse_hg_c%0d: got %0d want 0", c, bus.phase); end
      if (c == 3) bus.SN = 1'b1;
      if (c == 4) bus.SN = 1'b0;
      @(negedge clk);
    end
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < seq_n[s]; c++) begin
        n_checks++;
        if (bus.phase !== seq_ph[s]) begin n_fail++; $display("FAIL pulse_seq_s%0d_c%0d: got %0d want %0d", s, c, bus.phase, seq_ph[s]); end
        if (c == 0) begin
          n_checks++;
          if (bus.RedPixels !== exp_red(seq_ph[s], 1'b1) || bus.GrnPixels !== exp_grn(seq_ph[s], 1'b1))
          begin n_fail++; $display("FAIL pulse_px_ph%0d: red %h grn %h", seq_ph[s], bus.RedPixels, bus.GrnPixels); end
        end
        @(negedge clk);
      end
    end
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (bus.phase !== 3'd0) begin n_fail++; $display("FAIL pulse_req_cleared_c%0d: got %0d want 0", c, bus.phase); end
      @(negedge clk);
    end
  endtask

  task automatic test_side_hold();
    logic [2:0] seq_ph [5];
    int         seq_n  [5];
    seq_ph = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    seq_n  = '{8, 3, 2, 6, 3};
    apply_reset();
    @(negedge clk);
    @(negedge clk);
    bus.SS = 1'b1;
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < seq_n[s]; c++) begin
        n_checks++;
        if (bus.phase !== seq_ph[s]) begin n_fail++; $display("FAIL hold_seq_s%0d_c%0d: got %0d want %0d", s, c, bus.phase, seq_ph[s]); end
        @(negedge clk);
      end
    end
    bus.SS = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (bus.phase !== 3'd5) begin n_fail++; $display("FAIL hold_ar2_c%0d: got %0d want 5", c, bus.phase); end
      @(negedge clk);
    end
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if (bus.phase !== 3'd0) begin n_fail++; $display("FAIL hold_hg2_c%0d: got %0d want 0", c, bus.phase); end
      @(negedge clk);
    end
    n_checks++;
    if (bus.phase !== 3'd1) begin n_fail++; $display("FAIL hold_rereq_hy: got %0d want 1", bus.phase); end
  endtask

  task automatic test_flash();
    logic blk;
    apply_reset();
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (bus.phase !== 3'd0) begin n_fail++; $display("FAIL flash_hg_c%0d: got %0d want 0", c, bus.phase); end
      if (c == 1) bus.flash = 1'b1;
      @(negedge clk);
    end
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (bus.phase !== ((c < 3) ? 3'd1 : 3'd2)) begin n_fail++; $display("FAIL flash_exit_c%0d: got %0d want %0d", c, bus.phase, (c < 3) ? 1 : 2); end
      @(negedge clk);
    end
    for (int c = 0; c < 10; c++) begin
      blk = ((c / 4) % 2) == 0;
      n_checks++;
      if (bus.phase !== 3'd6) begin n_fail++; $display("FAIL flash_fl_c%0d: got %0d want 6", c, bus.phase); end
      n_checks++;
      if (bus.RedPixels !== exp_red(3'd6, blk) || bus.GrnPixels !== exp_grn(3'd6, blk))
      begin n_fail++; $display("FAIL flash_px_c%0d: red %h grn %h blink %0d", c, bus.RedPixels, bus.GrnPixels, blk); end
      @(negedge clk);
    end
    n_checks++;
    if (bus.RedPixels[0] !== 16'h00E0 || bus.GrnPixels[0] !== 16'h00E0)
    begin n_fail++; $display("FAIL flash_row0: red %h grn %h want 00e0", bus.RedPixels[0], bus.GrnPixels[0]); end
    bus.flash = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (bus.phase !== ((c < 2) ? 3'd5 : 3'd0)) begin n_fail++; $display("FAIL flash_leave_c%0d: got %0d want %0d", c, bus.phase, (c < 2) ? 5 : 0); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge clk);
    @(negedge clk);
    bus.SN = 1'b1;
    @(negedge clk);
    bus.SN = 1'b0;
    repeat (15) @(negedge clk);
    n_checks++;
    if (bus.phase !== 3'd3) begin n_fail++; $display("FAIL mid_sg_c4: got %0d want 3", bus.phase); end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.phase !== 3'd5) begin n_fail++; $display("FAIL mid_async_phase: got %0d want 5", bus.phase); end
    n_checks++;
    if (bus.RedPixels !== mk_px(1'b1, 1'b1) || bus.GrnPixels !== '0)
    begin n_fail++; $display("FAIL mid_async_px: red %h grn %h", bus.RedPixels, bus.GrnPixels); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 22; c++) begin
      n_checks++;
      if (bus.phase !== ((c < 2) ? 3'd5 : 3'd0)) begin n_fail++; $display("FAIL mid_after_c%0d: got %0d want %0d", c, bus.phase, (c < 2) ? 5 : 0); end
      @(negedge clk);
    end
  endtask

  task automatic test_short_params();
    logic [2:0] seq_ph [13];
    int         seq_n  [13];
    seq_ph = '{3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    seq_n  = '{1, 1, 1, 1, 6, 1, 1, 1, 1, 1, 6, 1, 1};
    bus_f.SN = 1'b1;
    apply_reset();
    for (int s = 0; s < 13; s++) begin
      for (int c = 0; c < seq_n[s]; c++) begin
        n_checks++;
        if (bus_f.phase !== seq_ph[s]) begin n_fail++; $display("FAIL short_seq_s%0d_c%0d: got %0d want %0d", s, c, bus_f.phase, seq_ph[s]); end
        @(negedge clk);
      end
    end
    n_checks++;
    if (bus_f.phase !== 3'd0) begin n_fail++; $display("FAIL short_repeat_hg: got %0d want 0", bus_f.phase); end
    bus_f.SN = 1'b0;
  endtask

  initial begin
    bus.SN = 1'b0;   bus.SS = 1'b0;   bus.flash = 1'b0;
    bus_f.SN = 1'b0; bus_f.SS = 1'b0; bus_f.flash = 1'b0;
    test_reset();
    test_side_pulse();
    test_side_hold();
    test_flash();
    test_reset_mid();
    test_short_params();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
